// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between ifetch and memctrl.
// Optional ICACHE_FLUSH_EN adds a flush input that invalidates every line.
module icache #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
`ifdef ICACHE_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        valid_from_ifetch,
  input  logic [31:0] pc_from_ifetch,
  output logic        valid_to_ifetch,
  output logic [31:0] inst_to_ifetch,
  output logic        valid_to_memctrl,
  output logic [31:0] addr_to_memctrl,
  input  logic        valid_from_memctrl,
  input  logic [31:0] data_from_memctrl
);

  // state   | meaning
  // IDLE    | waiting for a fetch request; lookup happens here
  // MISS    | memory read outstanding, waiting for the data pulse
  // RESPOND | response pulse on valid_to_ifetch; request input ignored
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {IDLE, MISS, RESPOND} state_e;

  state_e                 state_q, state_d;
  logic [29:0]            pc_q, pc_d;
  logic                   valid_to_ifetch_q, valid_to_ifetch_d;
  logic [31:0]            inst_q, inst_d;
  logic                   mem_req_q, mem_req_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [LINES-1:0]       line_valid_q, line_valid_d;
  logic [TAG_WIDTH-1:0]   tag_mem_q  [LINES];
  logic [31:0]            data_mem_q [LINES];

  logic                   flush_w;
  logic                   fill_we;
  logic                   hit;
  logic [INDEX_WIDTH-1:0] req_idx, fill_idx;
  logic [TAG_WIDTH-1:0]   req_tag, fill_tag;
  logic                   unused_pc_bits;

`ifdef ICACHE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign unused_pc_bits = ^pc_from_ifetch[1:0];
  assign req_idx  = pc_from_ifetch[INDEX_WIDTH+1:2];
  assign req_tag  = pc_from_ifetch[31:INDEX_WIDTH+2];
  assign fill_idx = pc_q[INDEX_WIDTH-1:0];
  assign fill_tag = pc_q[29:INDEX_WIDTH];
  // A flush on the lookup edge forces a miss, since the line is being invalidated.
  assign hit = line_valid_q[req_idx] && (tag_mem_q[req_idx] == req_tag) && !flush_w;

  always_comb begin
    state_d           = state_q;
    pc_d              = pc_q;
    valid_to_ifetch_d = 1'b0;
    inst_d            = inst_q;
    mem_req_d         = mem_req_q;
    mem_addr_d        = mem_addr_q;
    fill_we           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_from_ifetch) begin
          if (hit) begin
            valid_to_ifetch_d = 1'b1;
            inst_d            = data_mem_q[req_idx];
            state_d           = RESPOND;
          end else begin
            pc_d       = pc_from_ifetch[31:2];
            mem_req_d  = 1'b1;
            mem_addr_d = {pc_from_ifetch[31:2], 2'b00};
            state_d    = MISS;
          end
        end
      end
      MISS: begin
        if (valid_from_memctrl) begin
          fill_we           = !flush_w;
          mem_req_d         = 1'b0;
          valid_to_ifetch_d = 1'b1;
          inst_d            = data_from_memctrl;
          state_d           = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    line_valid_d = line_valid_q;
    if (flush_w)      line_valid_d = '0;
    else if (fill_we) line_valid_d[fill_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      pc_q              <= '0;
      valid_to_ifetch_q <= 1'b0;
      inst_q            <= '0;
      mem_req_q         <= 1'b0;
      mem_addr_q        <= '0;
      line_valid_q      <= '0;
    end else if (rdy) begin
      state_q           <= state_d;
      pc_q              <= pc_d;
      valid_to_ifetch_q <= valid_to_ifetch_d;
      inst_q            <= inst_d;
      mem_req_q         <= mem_req_d;
      mem_addr_q        <= mem_addr_d;
      line_valid_q      <= line_valid_d;
    end
  end

  // Tag and data storage carry no reset; line_valid_q guards them.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we) begin
      tag_mem_q[fill_idx]  <= fill_tag;
      data_mem_q[fill_idx] <= data_from_memctrl;
    end
  end

  assign valid_to_ifetch  = valid_to_ifetch_q;
  assign inst_to_ifetch   = inst_q;
  assign valid_to_memctrl = mem_req_q;
  assign addr_to_memctrl  = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// compared against a line-array model of a direct-mapped cache.
module tb_icache;
  localparam int IW    = 8;
  localparam int LINES = 1 << IW;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        valid_from_ifetch;
  logic [31:0] pc_from_ifetch;
  logic        valid_to_ifetch;
  logic [31:0] inst_to_ifetch;
  logic        valid_to_memctrl;
  logic [31:0] addr_to_memctrl;
  logic        valid_from_memctrl;
  logic [31:0] data_from_memctrl;

  icache #(.INDEX_WIDTH(IW)) dut (
    .clk                (clk),
    .rst                (rst),
    .rdy                (rdy),
`ifdef ICACHE_FLUSH_EN
    .flush              (flush),
`endif
    .valid_from_ifetch  (valid_from_ifetch),
    .pc_from_ifetch     (pc_from_ifetch),
    .valid_to_ifetch    (valid_to_ifetch),
    .inst_to_ifetch     (inst_to_ifetch),
    .valid_to_memctrl   (valid_to_memctrl),
    .addr_to_memctrl    (addr_to_memctrl),
    .valid_from_memctrl (valid_from_memctrl),
    .data_from_memctrl  (data_from_memctrl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES];
  logic [31:0] last_inst;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // One complete fetch transaction, expected outcome taken from the model.
  task automatic fetch(input logic [31:0] pc, input int delay, input logic [31:0] mdata,
                       input bit stall, input bit hold, input bit flush_now);
    int  idx;
    bit  hit;
    idx = int'((pc >> 2) % LINES);
    if (flush_now) model_clear();
    hit = m_valid[idx] && (m_tag[idx] == (pc >> (IW + 2)));
    valid_from_ifetch = 1'b1;
    pc_from_ifetch    = pc;
    flush             = flush_now;
    step();
    flush = 1'b0;
    if (hit) begin
      chk("hit_vld", 32'(valid_to_ifetch), 32'd1);
      chk("hit_inst", inst_to_ifetch, m_data[idx]);
      chk("hit_nomem", 32'(valid_to_memctrl), 32'd0);
      last_inst = m_data[idx];
    end else begin
      chk("miss_req", 32'(valid_to_memctrl), 32'd1);
      chk("miss_addr", addr_to_memctrl, {pc[31:2], 2'b00});
      chk("miss_novld", 32'(valid_to_ifetch), 32'd0);
      pc_from_ifetch = $urandom;
      for (int d = 0; d < delay; d++) begin
        step();
        chk("miss_hold", 32'(valid_to_memctrl), 32'd1);
        chk("miss_hold_addr", addr_to_memctrl, {pc[31:2], 2'b00});
      end
      if (stall) begin
        rdy                = 1'b0;
        valid_from_memctrl = 1'b1;
        data_from_memctrl  = ~mdata;
        for (int s = 0; s < 3; s++) begin
          step();
          chk("stall_req", 32'(valid_to_memctrl), 32'd1);
          chk("stall_novld", 32'(valid_to_ifetch), 32'd0);
        end
        valid_from_memctrl = 1'b0;
        rdy                = 1'b1;
        step();
        chk("stall_still_miss", 32'(valid_to_memctrl), 32'd1);
      end
      valid_from_memctrl = 1'b1;
      data_from_memctrl  = mdata;
      step();
      valid_from_memctrl = 1'b0;
      data_from_memctrl  = $urandom;
      chk("fill_vld", 32'(valid_to_ifetch), 32'd1);
      chk("fill_inst", inst_to_ifetch, mdata);
      chk("fill_memdrop", 32'(valid_to_memctrl), 32'd0);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = pc >> (IW + 2);
      m_data[idx]  = mdata;
      last_inst    = mdata;
    end
    if (!hold) valid_from_ifetch = 1'b0;
    step();
    chk("resp_once", 32'(valid_to_ifetch), 32'd0);
    chk("inst_hold", inst_to_ifetch, last_inst);
    if (hold) begin
      valid_from_ifetch = 1'b0;
      step();
      chk("no_relookup_vld", 32'(valid_to_ifetch), 32'd0);
      chk("no_relookup_mem", 32'(valid_to_memctrl), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    valid_from_ifetch = 1'b0; pc_from_ifetch = '0;
    valid_from_memctrl = 1'b0; data_from_memctrl = '0;
    last_inst = '0;
    model_clear();
    step(); step();
    rst = 1'b0;
    chk("rst_vld", 32'(valid_to_ifetch), 32'd0);
    chk("rst_inst", inst_to_ifetch, 32'd0);
    chk("rst_mem", 32'(valid_to_memctrl), 32'd0);
    chk("rst_addr", addr_to_memctrl, 32'd0);

    // Cold miss, then hit, then hit with request held through the response.
    fetch(32'h10, 5, 32'h00500093, 1'b0, 1'b0, 1'b0);
    fetch(32'h10, 0, 32'h0, 1'b0, 1'b0, 1'b0);
    fetch(32'h10, 0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Conflict on the same index evicts the earlier line.
    fetch(32'h410, 2, 32'h11111111, 1'b0, 1'b0, 1'b0);
    fetch(32'h10, 1, 32'h00500093, 1'b0, 1'b0, 1'b0);

    // rdy stall during a miss, with the memctrl pulse arriving while stalled.
    fetch(32'h84, 1, 32'hcafe0001, 1'b1, 1'b0, 1'b0);

    // rdy low in IDLE: request is not accepted.
    rdy = 1'b0; valid_from_ifetch = 1'b1; pc_from_ifetch = 32'h200;
    step(); step();
    chk("rdy_idle_mem", 32'(valid_to_memctrl), 32'd0);
    chk("rdy_idle_vld", 32'(valid_to_ifetch), 32'd0);
    valid_from_ifetch = 1'b0; rdy = 1'b1;
    step();

    // Reset mid-miss abandons the request; a stray pulse afterwards is ignored.
    valid_from_ifetch = 1'b1; pc_from_ifetch = 32'h300;
    step();
    chk("rmid_req", 32'(valid_to_memctrl), 32'd1);
    valid_from_ifetch = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    model_clear();
    last_inst = '0;
    chk("rmid_mem", 32'(valid_to_memctrl), 32'd0);
    chk("rmid_addr", addr_to_memctrl, 32'd0);
    chk("rmid_inst", inst_to_ifetch, 32'd0);
    valid_from_memctrl = 1'b1; data_from_memctrl = 32'hdeadbeef;
    step();
    valid_from_memctrl = 1'b0;
    chk("stray_vld", 32'(valid_to_ifetch), 32'd0);
    chk("stray_inst", inst_to_ifetch, 32'd0);
    fetch(32'h10, 0, 32'h00500093, 1'b0, 1'b0, 1'b0);

`ifdef ICACHE_FLUSH_EN
    fetch(32'h20, 1, 32'h22222222, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_clear();
    fetch(32'h20, 1, 32'h22222222, 1'b0, 1'b0, 1'b0);
    fetch(32'h20, 0, 32'h33333333, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic over a few indices and tags to mix hits and conflicts.
    for (int n = 0; n < 150; n++) begin
      pc = (32'($urandom_range(0, 2)) << (IW + 2)) | (32'($urandom_range(0, 3)) << 2)
           | 32'($urandom_range(0, 3));
      fetch(pc, $urandom_range(0, 4), $urandom, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0), 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache.
- Responder on the fetch-request interface driven by the instruction-fetch unit.
- Initiator on a word-level read interface to the memory controller.
- Services one outstanding fetch at a time: hits from the local array, misses by a memory read followed by a line fill.

Parameters:
INDEX_WIDTH, 8, log2 of line count (256 lines); index = pc[INDEX_WIDTH+1:2]
TAG_WIDTH, 30-INDEX_WIDTH (derived localparam), tag = pc[31:INDEX_WIDTH+2]

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
rdy  input  1  global ready; low = hold all state and outputs
valid_from_ifetch  input  1  fetch request valid; held high by fetcher until served
pc_from_ifetch  input  32  fetch address, stable while request valid; bits [1:0] ignored
valid_to_ifetch  output  1  one-cycle pulse: inst_to_ifetch is valid
inst_to_ifetch  output  32  returned instruction word
valid_to_memctrl  output  1  memory read request, held until done
addr_to_memctrl  output  32  word address of read, {pc[31:2],2'b00}
valid_from_memctrl  input  1  one-cycle pulse: read data valid
data_from_memctrl  input  32  read data word

Behaviour:
- Clock is clk; reset is synchronous, active-high, on rst. At rst, all line valid bits are cleared. Tag and data arrays are not reset.
- Reset values: valid_to_ifetch=0, inst_to_ifetch=0, valid_to_memctrl=0, addr_to_memctrl=0, state=IDLE.
- rst has priority over rdy. rst mid-miss abandons the request and returns to IDLE; a later memctrl pulse is ignored in IDLE.
- rdy=0: no state, array or output register changes.
- FSM states IDLE, MISS, RESPOND. All outputs are registered.
- IDLE, valid_from_ifetch=0: hold state; valid_to_ifetch=0.
- IDLE, request, hit (line valid and tag equal): next cycle valid_to_ifetch=1, inst_to_ifetch=line data; go to RESPOND. Hit latency is 1 cycle.
- IDLE, request, miss: latch pc. Next cycle valid_to_memctrl=1 and addr_to_memctrl=aligned pc; go to MISS.
- MISS: hold valid_to_memctrl and addr until valid_from_memctrl=1. On that edge:
  - write data, tag and valid=1 into the indexed line;
  - drop valid_to_memctrl;
  - drive valid_to_ifetch=1 and inst_to_ifetch=data_from_memctrl the following cycle;
  - go to RESPOND.
- RESPOND: valid_to_ifetch is high for exactly this cycle. The request input is ignored this cycle, because the fetcher still holds the old request until it samples the pulse. Next state is IDLE with valid_to_ifetch=0. inst_to_ifetch holds its value until the next response.
- An accepted request always completes; there is no abort input. The fetcher discards stale responses after rollback itself.
- A conflicting line is overwritten on fill (no write-back; the cache is read-only).
- Max throughput: one response per 2 cycles on back-to-back hits.
- The request's pc is latched at acceptance. Later changes to pc_from_ifetch do not affect the in-flight miss.

Optional Feature:
ICACHE_FLUSH_EN:
- Defined: adds input port flush (1 bit). When flush=1 and rdy=1, all valid bits clear at that edge.
- Flush while in MISS: the fill response is still returned to ifetch, but the line is not written.
- Flush and a fill on the same edge: the line is not written.
- Flush in IDLE with a simultaneous request: the lookup treats it as a miss.
- Undefined: no flush port; valid bits clear only on rst.

Test Plan:
- Cold miss: after rst, request pc=0x00000010. Required response:
  - next cycle valid_to_memctrl=1, addr=0x10;
  - memctrl returns 0x00500093 after 5 cycles;
  - 1 cycle later valid_to_ifetch pulses 1 cycle with inst 0x00500093.
- Hit: re-request pc=0x10 -> valid_to_ifetch pulse 1 cycle after acceptance, inst 0x00500093, valid_to_memctrl stays 0.
- Conflict: fill pc=0x10, then pc=0x410 (same index with INDEX_WIDTH=8) with data 0x11111111, then pc=0x10 -> third request misses again, addr=0x10.
- Request held through RESPOND: keep valid_from_ifetch high for 1 cycle after the pulse -> exactly one pulse, no second lookup.
- rdy stall: drop rdy for 3 cycles during MISS while memctrl pulses -> state frozen, pulse not consumed while rdy=0. Bench re-pulses after rdy=1 -> normal response.
- Flush (ICACHE_FLUSH_EN): fill pc=0x20, assert flush 1 cycle, request pc=0x20 -> miss, valid_to_memctrl=1, addr=0x20.
